image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer.sv | 143 ++++++++++++++
 tb/tb_image_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// Streams one DEPTH-pixel image from a synchronous-read block memory onto a
// valid/ready pixel port through a 2-entry output FIFO.
module image_streamer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state;
    state_t            state_n;
    logic              rd_pend;
    logic              rd_pend_last;
    logic              pop;
    logic              last_issue;
    logic [1:0]        level;
    logic [DATA_W-1:0] tail_data;
    logic              tail_valid;
    logic              tail_last;
    logic [DATA_W-1:0] head_data_n;
    logic              head_valid_n;
    logic              head_last_n;
    logic [DATA_W-1:0] tail_data_n;
    logic              tail_valid_n;
    logic              tail_last_n;

    assign pop        = px_valid & px_ready;
    assign last_issue = mem_en && (mem_addr == LAST_ADDR);

    // Slots committed to pixels; a head pixel leaving this cycle frees its slot.
    assign level = 2'(px_valid) + 2'(tail_valid) + 2'(rd_pend) - 2'(pop);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (last_issue) state_n = DRAIN;
            DRAIN:   if (pop && px_last) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read issue
    always_comb begin
        mem_en = 1'b0;
        if (state == READ && level < 2'd2) mem_en = 1'b1;
    end

    // Address counter and one-cycle read-return tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr     <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= mem_en;
            rd_pend_last <= last_issue;
            if (mem_en) mem_addr <= last_issue ? '0 : mem_addr + ADDR_W'(1);
        end
    end

    // Shift FIFO: the head entry drives the pixel port directly
    always_comb begin
        head_data_n  = px_data;
        head_valid_n = px_valid;
        head_last_n  = px_last;
        tail_data_n  = tail_data;
        tail_valid_n = tail_valid;
        tail_last_n  = tail_last;
        if (pop) begin
            head_data_n  = tail_data;
            head_valid_n = tail_valid;
            head_last_n  = tail_last;
            tail_valid_n = 1'b0;
            tail_last_n  = 1'b0;
        end
        if (rd_pend) begin
            if (!head_valid_n) begin
                head_data_n  = mem_rdata;
                head_valid_n = 1'b1;
                head_last_n  = rd_pend_last;
            end else begin
                tail_data_n  = mem_rdata;
                tail_valid_n = 1'b1;
                tail_last_n  = rd_pend_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_data    <= '0;
            px_valid   <= 1'b0;
            px_last    <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
        end else begin
            px_data    <= head_data_n;
            px_valid   <= head_valid_n;
            px_last    <= head_last_n;
            tail_data  <= tail_data_n;
            tail_valid <= tail_valid_n;
            tail_last  <= tail_last_n;
        end
    end

    // Status flags registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == READ) || (state_n == DRAIN);
            done <= (state_n == FIN);
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// Randomized bench for image_streamer: a pixel-index model of the image checks
// every transfer, stall, read issue and status flag against the memory contents.
module tb_image_streamer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    // Model: phase 0 idle, 1 streaming, 2 done cycle
    int phase       = 0;
    int since_start = 0;
    int issued      = 0;
    int xfers       = 0;
    int done_cnt    = 0;
    int mode        = 0;
    int kcyc        = 0;
    bit mon_en      = 0;
    bit stall_prev  = 0;
    bit prev_last   = 0;
    logic [DATA_W-1:0] prev_data = '0;

    image_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_last   (px_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read block memory
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int m, input int k);
        case (m)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_reset_outputs();
        check("rst_mem_en",   32'(mem_en),   32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_px_valid", 32'(px_valid), 32'(0));
        check("rst_px_last",  32'(px_last),  32'(0));
        check("rst_px_data",  32'(px_data),  32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_done",     32'(done),     32'(0));
    endtask

    task automatic model_clear();
        phase = 0; since_start = 0; issued = 0; xfers = 0; stall_prev = 0;
    endtask

    // Compare one sampled cycle with the image model, then advance the model
    task automatic monitor();
        bit xfer;
        check("busy", 32'(busy), 32'(phase == 1));
        check("done", 32'(done), 32'(phase == 2));
        if (phase == 2 && done) done_cnt++;
        if (phase == 1) begin
            since_start++;
            if (since_start <= 2)
                check("first_valid_early", 32'(px_valid), 32'(0));
            else if (since_start == 3)
                check("first_valid_lat", 32'(px_valid), 32'(1));
            else if (mode == 0 && xfers < DEPTH)
                check("gapless", 32'(px_valid), 32'(1));
        end else begin
            check("idle_valid", 32'(px_valid), 32'(0));
        end
        if (mem_en) begin
            check("mem_en_phase", 32'(phase == 1), 32'(1));
            check("mem_addr", 32'(mem_addr), 32'(issued));
            check("over_issue", 32'(issued < DEPTH), 32'(1));
            issued++;
        end
        if (stall_prev) begin
            check("stall_valid", 32'(px_valid), 32'(1));
            check("stall_data",  32'(px_data),  32'(prev_data));
            check("stall_last",  32'(px_last),  32'(prev_last));
        end
        xfer = px_valid && px_ready;
        if (xfer) begin
            check("extra_xfer", 32'(xfers < DEPTH), 32'(1));
            if (xfers < DEPTH) begin
                check("px_data", 32'(px_data), 32'(mem[xfers]));
                check("px_last", 32'(px_last), 32'(xfers == DEPTH - 1));
            end
            xfers++;
        end else if (!px_valid) begin
            check("px_last_empty", 32'(px_last), 32'(0));
        end
        check("outstanding", 32'((issued - xfers) <= 2), 32'(1));
        stall_prev = px_valid && !px_ready;
        prev_data  = px_data;
        prev_last  = px_last;
        case (phase)
            0: if (start) begin
                phase = 1; since_start = 0; issued = 0; xfers = 0;
            end
            1: if (xfer && xfers == DEPTH) phase = 2;
            default: phase = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        kcyc++;
    endtask

    task automatic finish_image(input int target, input int budget);
        while ((done_cnt < target || phase != 0) && kcyc < budget) begin
            px_ready = ready_for(mode, kcyc);
            cycle();
        end
        check("image_done_cnt", 32'(done_cnt), 32'(target));
        check("image_xfers",    32'(xfers),    32'(DEPTH));
        repeat (2) cycle();
    endtask

    task automatic run_image(input int m, input int budget);
        int target;
        target   = done_cnt + 1;
        mode     = m;
        kcyc     = 0;
        start    = 1'b1;
        px_ready = ready_for(m, kcyc);
        cycle();
        start = 1'b0;
        finish_image(target, budget);
    endtask

    initial begin
        int target;
        bit pulsed;
        reset = 1'b0; start = 1'b0; px_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Full-rate stream of 1..64
        run_image(0, 200);

        // Ready pattern 1,0,0,1
        run_image(1, 400);

        // Downstream held off for 10 cycles after start
        target = done_cnt + 1;
        mode = 9; kcyc = 0;
        start = 1'b1; px_ready = 1'b0;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        check("stall_reads",    32'(issued),   32'(2));
        check("stall_px_valid", 32'(px_valid), 32'(1));
        check("stall_px_data",  32'(px_data),  32'(1));
        check("stall_mem_en",   32'(mem_en),   32'(0));
        finish_image(target, 300);

        // Start pulses mid-image and in the done cycle are ignored
        target = done_cnt + 1;
        mode = 0; kcyc = 0; pulsed = 0;
        start = 1'b1; px_ready = 1'b1;
        cycle();
        start = 1'b0;
        while ((done_cnt < target || phase != 0) && kcyc < 200) begin
            start = 1'b0;
            if (xfers == 30 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (phase == 2) start = 1'b1;
            cycle();
        end
        start = 1'b0;
        repeat (6) cycle();
        check("restart_done_cnt", 32'(done_cnt), 32'(target));
        check("restart_xfers",    32'(xfers),    32'(DEPTH));

        // Reset at pixel 20, then a fresh image from address 0
        mode = 0; kcyc = 0;
        start = 1'b1; px_ready = 1'b1;
        cycle();
        start = 1'b0;
        while (xfers < 20 && kcyc < 200) cycle();
        check("reached_px20", 32'(xfers), 32'(20));
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        model_clear();
        mon_en = 1'b1;
        repeat (2) cycle();
        run_image(0, 200);

        // Random pixel data with random backpressure
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
            run_image(2, 800);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
